// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions for the fetch stage: address width, reset vector,
// FSM state encoding and the next-PC source select.
package fetch_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_MISS_WAIT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4    = 2'd0,
    PC_SEL_BP       = 2'd1,
    PC_SEL_REDIRECT = 2'd2,
    PC_SEL_PENDING  = 2'd3
  } pc_sel_e;

  // Loaded targets are always word aligned.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc.sv
// ProgramCounter register: selects the next-PC source and loads it when enabled.
module fetch_ctrl_pc
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  pc_sel_e           sel_i,
  input  logic [ADDR_W-1:0] plus4_i,
  input  logic [ADDR_W-1:0] bp_target_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  input  logic [ADDR_W-1:0] pending_target_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = plus4_i;
    case (sel_i)
      PC_SEL_PLUS4:    pc_d = plus4_i;
      PC_SEL_BP:       pc_d = align_word(bp_target_i);
      PC_SEL_REDIRECT: pc_d = align_word(redirect_target_i);
      PC_SEL_PENDING:  pc_d = align_word(pending_target_i);
      default:         pc_d = plus4_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= RESET_VECTOR;
    end else if (en_i) begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: next-PC arbitration, I-cache miss wait with deferred
// redirect, decode flush and a saturating miss-cycle counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  input  logic              stall_i,
  input  logic              bp_hit_i,
  input  logic [ADDR_W-1:0] bp_target_i,
  input  logic              icache_miss_i,
  input  logic              icache_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_4_o,
  output logic              fetch_valid_o,
  output logic              flush_d_o,
  output logic [CNT_W-1:0]  miss_cycles_o
);

  fetch_state_e      state_q, state_d;
  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_q;
  logic [CNT_W-1:0]  miss_q;
  logic              pc_en;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc;

  assign pc_plus_4_o = pc + ADDR_W'(4);
  assign pc_o        = pc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!redirect_i && !stall_i && icache_miss_i) state_d = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (icache_ready_i) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Outputs and PC load control; everything is forced quiet while in reset.
  always_comb begin
    fetch_valid_o = 1'b0;
    flush_d_o     = 1'b0;
    pc_en         = 1'b0;
    pc_sel        = PC_SEL_PLUS4;
    if (!reset_i) begin
      case (state_q)
        ST_RUN: begin
          fetch_valid_o = !(icache_miss_i || redirect_i);
          if (redirect_i) begin
            flush_d_o = 1'b1;
            pc_en     = 1'b1;
            pc_sel    = PC_SEL_REDIRECT;
          end else if (!stall_i && !icache_miss_i) begin
            pc_en  = 1'b1;
            pc_sel = bp_hit_i ? PC_SEL_BP : PC_SEL_PLUS4;
          end
        end
        ST_MISS_WAIT: begin
          flush_d_o = redirect_i;
          if (icache_ready_i && redirect_i) begin
            pc_en  = 1'b1;
            pc_sel = PC_SEL_REDIRECT;
          end else if (icache_ready_i && pend_v_q) begin
            pc_en  = 1'b1;
            pc_sel = PC_SEL_PENDING;
          end
        end
        default: ;
      endcase
    end
  end

  // Redirects arriving during a refill are parked until the refill completes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_v_q <= 1'b0;
      pend_q   <= '0;
    end else if (state_q == ST_MISS_WAIT) begin
      if (icache_ready_i) begin
        pend_v_q <= 1'b0;
      end else if (redirect_i) begin
        pend_v_q <= 1'b1;
        pend_q   <= align_word(redirect_target_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      miss_q <= '0;
    end else if (state_q == ST_MISS_WAIT && miss_q != '1) begin
      miss_q <= miss_q + CNT_W'(1);
    end
  end

  assign miss_cycles_o = miss_q;

  fetch_ctrl_pc #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .en_i             (pc_en),
    .sel_i            (pc_sel),
    .plus4_i          (pc_plus_4_o),
    .bp_target_i      (bp_target_i),
    .redirect_target_i(redirect_target_i),
    .pending_target_i (pend_q),
    .pc_o             (pc)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural fetch model.
module tb_fetch_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             redirect;
  logic [31:0]      redirect_target;
  logic             stall;
  logic             bp_hit;
  logic [31:0]      bp_target;
  logic             icache_miss;
  logic             icache_ready;
  logic [31:0]      pc;
  logic [31:0]      pc_plus_4;
  logic             fetch_valid;
  logic             flush_d;
  logic [CNT_W-1:0] miss_cycles;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl #(
    .RESET_VECTOR(RV),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .redirect_i       (redirect),
    .redirect_target_i(redirect_target),
    .stall_i          (stall),
    .bp_hit_i         (bp_hit),
    .bp_target_i      (bp_target),
    .icache_miss_i    (icache_miss),
    .icache_ready_i   (icache_ready),
    .pc_o             (pc),
    .pc_plus_4_o      (pc_plus_4),
    .fetch_valid_o    (fetch_valid),
    .flush_d_o        (flush_d),
    .miss_cycles_o    (miss_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where fetch is, whether it is booting or waiting on a refill.
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_pend_v;
  bit          m_boot;
  bit          m_in_miss;
  bit          m_valid = 1'b0;
  int unsigned m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_pc      = RV;
      m_pend_v  = 1'b0;
      m_pend    = '0;
      m_boot    = 1'b1;
      m_in_miss = 1'b0;
      m_cnt     = 0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_in_miss) begin
        if (redirect)         m_pc = redirect_target & 32'hFFFF_FFFC;
        else if (stall)       m_pc = m_pc;
        else if (icache_miss) m_in_miss = 1'b1;
        else if (bp_hit)      m_pc = bp_target & 32'hFFFF_FFFC;
        else                  m_pc = m_pc + 32'd4;
      end else begin
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (icache_ready) begin
          m_in_miss = 1'b0;
          if (redirect)      m_pc = redirect_target & 32'hFFFF_FFFC;
          else if (m_pend_v) m_pc = m_pend;
          m_pend_v = 1'b0;
        end else if (redirect) begin
          m_pend   = redirect_target & 32'hFFFF_FFFC;
          m_pend_v = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_fv;
    logic exp_fl;
    if (m_valid) begin
      exp_fl = !reset && !m_boot && redirect;
      exp_fv = !reset && !m_boot && !m_in_miss && !redirect && !icache_miss;
      chk("model_pc", pc, m_pc);
      chk("model_pc_plus_4", pc_plus_4, m_pc + 32'd4);
      chk("model_fetch_valid", 32'(fetch_valid), 32'(exp_fv));
      chk("model_flush_d", 32'(flush_d), 32'(exp_fl));
      chk("model_miss_cycles", 32'(miss_cycles), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset           = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    stall           = 1'b0;
    bp_hit          = 1'b0;
    bp_target       = '0;
    icache_miss     = 1'b0;
    icache_ready    = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect        = 1'b1;
    redirect_target = tgt;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    do_redirect(32'h0000_1234);
    @(negedge clk);
    chk("rst_flush", 32'(flush_d), 32'd0);
    chk("rst_pc", pc, RV);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("boot_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("boot_pc", pc, 32'h0);
    tick();
    @(negedge clk);
    chk("run_pc0", pc, 32'h0);
    chk("run_fetch_valid", 32'(fetch_valid), 32'd1);
    tick(); @(negedge clk); chk("seq_pc4", pc, 32'h4);
    tick(); @(negedge clk); chk("seq_pc8", pc, 32'h8);
    tick(); @(negedge clk); chk("seq_pc12", pc, 32'hC);
    tick();
    do_redirect(32'h2914_AB4E);
    @(negedge clk);
    chk("redir_pc10", pc, 32'h10);
    chk("redir_flush", 32'(flush_d), 32'd1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_target", pc, 32'h2914_AB4C);

    // Miss at 0x20 lasting five refill cycles.
    do_redirect(32'h20);
    tick();
    redirect    = 1'b0;
    icache_miss = 1'b1;
    @(negedge clk);
    chk("miss_fetch_valid", 32'(fetch_valid), 32'd0);
    tick();
    icache_miss = 1'b0;
    repeat (4) tick();
    icache_ready = 1'b1;
    @(negedge clk);
    chk("miss_hold_pc", pc, 32'h20);
    chk("miss_cnt_4", 32'(miss_cycles), 32'd4);
    tick();
    icache_ready = 1'b0;
    @(negedge clk);
    chk("miss_refetch_pc", pc, 32'h20);
    chk("miss_cnt_5", 32'(miss_cycles), 32'd5);
    chk("miss_resume_valid", 32'(fetch_valid), 32'd1);
    tick(); @(negedge clk); chk("miss_next_pc", pc, 32'h24);

    // Two redirects parked during a refill; the later one wins.
    icache_miss = 1'b1;
    tick();
    icache_miss = 1'b0;
    do_redirect(32'h100);
    @(negedge clk);
    chk("mw_flush", 32'(flush_d), 32'd1);
    tick();
    do_redirect(32'h200);
    tick();
    redirect = 1'b0;
    tick();
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    @(negedge clk);
    chk("pend_target", pc, 32'h200);
    tick(); @(negedge clk); chk("pend_next", pc, 32'h204);
    icache_miss = 1'b1;
    tick();
    icache_miss  = 1'b0;
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    @(negedge clk);
    chk("pend_cleared", pc, 32'h204);

    // Redirect coinciding with refill completion beats the parked target.
    icache_miss = 1'b1;
    tick();
    icache_miss = 1'b0;
    do_redirect(32'h300);
    tick();
    do_redirect(32'h401);
    icache_ready = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("ready_redirect", pc, 32'h400);

    // Priority: redirect over stall over branch prediction.
    do_redirect(32'h40);
    stall     = 1'b1;
    bp_hit    = 1'b1;
    bp_target = 32'h80;
    @(negedge clk);
    chk("prio_flush", 32'(flush_d), 32'd1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("prio_redirect", pc, 32'h40);
    tick(); @(negedge clk); chk("prio_stall", pc, 32'h40);
    stall = 1'b0;
    tick(); @(negedge clk); chk("prio_bp", pc, 32'h80);
    bp_hit = 1'b0;

    // Counter saturation (12 cycles accumulated so far).
    icache_miss = 1'b1;
    tick();
    icache_miss = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("miss_cnt_sat", 32'(miss_cycles), CNT_MAX);
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;

    // Wrap, then reset in the middle of a refill with a parked redirect.
    do_redirect(32'hFFFF_FFFF);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus_4, 32'h0);
    tick(); @(negedge clk); chk("wrap_next", pc, 32'h0);
    icache_miss = 1'b1;
    tick();
    icache_miss = 1'b0;
    do_redirect(32'h500);
    tick();
    redirect = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rstmw_fetch_valid", 32'(fetch_valid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstmw_pc", pc, RV);
    chk("rstmw_cnt", 32'(miss_cycles), 32'd0);
    chk("rstmw_boot_valid", 32'(fetch_valid), 32'd0);
    tick(); @(negedge clk); chk("rstmw_no_pend", pc, RV);
    tick(); @(negedge clk); chk("rstmw_next", pc, RV + 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset           = ($urandom_range(0, 399) == 0);
      redirect        = ($urandom_range(0, 15) == 0);
      redirect_target = $urandom();
      stall           = ($urandom_range(0, 7) == 0);
      bp_hit          = ($urandom_range(0, 7) == 0);
      bp_target       = $urandom();
      icache_miss     = ($urandom_range(0, 9) == 0);
      icache_ready    = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Parameter CNT_W, default 16, width of the miss-cycle performance counter.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Redirect  input  1  resolved branch mispredict or taken PCSrc from execute; highest priority.
REQ-006 Redirect_Target  input  32  correct next PC accompanying Redirect.
REQ-007 Stall  input  1  hazard-unit freeze of the fetch stage.
REQ-008 BP_Hit  input  1  branch predictor hit for the current PC.
REQ-009 BP_Target  input  32  predicted target accompanying BP_Hit.
REQ-010 ICache_Miss  input  1  I-cache miss on the current PC, valid in RUN.
REQ-011 ICache_Ready  input  1  refill complete, one-cycle pulse.
REQ-012 PC  output  32  registered fetch address.
REQ-013 PC_Plus_4  output  32  combinational PC + 4.
REQ-014 Fetch_Valid  output  1  instruction at PC is delivered this cycle.
REQ-015 Flush_D  output  1  combinational; kill the decode-stage instruction.
REQ-016 Miss_Cycles  output  CNT_W  saturating count of cycles spent in MISS_WAIT.

Function
REQ-017 FSM states SHALL be BOOT, RUN, MISS_WAIT.
REQ-018 BOOT SHALL last exactly one cycle after Reset deasserts, with Fetch_Valid=0, then SHALL go to RUN with PC unchanged.
REQ-019 In RUN, next-PC priority SHALL be: Redirect > Stall > ICache_Miss > BP_Hit > PC_Plus_4.
REQ-020 Redirect in RUN SHALL load PC<=Redirect_Target on the next edge and assert Flush_D in the same cycle, even when Stall or ICache_Miss is also asserted.
REQ-021 Stall without Redirect SHALL hold PC and hold the state.
REQ-022 ICache_Miss without Redirect or Stall SHALL hold PC, drive Fetch_Valid=0, and move to MISS_WAIT.
REQ-023 BP_Hit with no higher-priority event SHALL load PC<=BP_Target.
REQ-024 Otherwise PC SHALL load PC_Plus_4.
REQ-025 Fetch_Valid SHALL be 1 in RUN unless ICache_Miss or Redirect is asserted that cycle, and 0 in BOOT and MISS_WAIT.
REQ-026 In MISS_WAIT, PC SHALL hold until ICache_Ready.
REQ-027 On ICache_Ready in MISS_WAIT, the FSM SHALL return to RUN, and PC SHALL stay unchanged so the missed address is refetched.
REQ-028 A Redirect during MISS_WAIT SHALL assert Flush_D and latch Redirect_Target in a pending register with a pending flag; a later Redirect SHALL overwrite it.
REQ-029 On leaving MISS_WAIT with the pending flag set, PC SHALL load the pending target and the flag SHALL clear.
REQ-030 If Redirect and ICache_Ready coincide, Redirect_Target SHALL win and be loaded directly.
REQ-031 All loaded targets SHALL have bits [1:0] forced to 0.
REQ-032 PC_Plus_4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-033 Miss_Cycles SHALL increment once per MISS_WAIT cycle and saturate at all-ones.

Reset
REQ-034 Reset SHALL set PC=RESET_VECTOR, state=BOOT, pending flag=0, Miss_Cycles=0, Fetch_Valid=0, and Flush_D=0.
REQ-035 Reset SHALL take precedence over every other input, including in mid-MISS_WAIT, and any pending redirect SHALL be discarded.

Structure
REQ-036 The state encoding (BOOT, RUN, MISS_WAIT) and the RESET_VECTOR default SHALL reside in the shared core package.
REQ-037 The existing ProgramCounter register SHALL be instantiated as the sole sub-module, with fetch_ctrl supplying its next-PC select and enable; all other logic SHALL be inline.

Verification
REQ-038 Reset for 2 cycles, then release -> PC=0, one cycle Fetch_Valid=0, then PC=4,8,12 on consecutive edges.
REQ-039 At PC=0x10, assert Redirect with target 0x2914AB4E -> Flush_D=1 that cycle, next PC=0x2914AB4C.
REQ-040 At PC=0x20, assert ICache_Miss for 1 cycle, hold 5 cycles, then pulse ICache_Ready -> PC held at 0x20, Miss_Cycles=5 at the end of MISS_WAIT, and fetch resumes at 0x20 then 0x24.
REQ-041 During MISS_WAIT, Redirect to 0x100 then Redirect to 0x200, then ICache_Ready -> PC=0x200, pending flag cleared.
REQ-042 Same cycle Redirect(0x40), Stall, and BP_Hit(0x80) -> PC=0x40; with Stall and BP_Hit only -> PC held.
REQ-043 Load 0xFFFFFFFC via Redirect, then run -> next PC=0x0; assert Reset mid-MISS_WAIT -> PC=RESET_VECTOR, state BOOT, Miss_Cycles=0.
